// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/load-store memory
// arbiter. It holds the bus widths, the arbiter state encoding, the captured
// memory command record and two small address/data helpers.
package mem_arbiter_pkg;

    localparam int MEM_AW = 64;            // memory byte-address width
    localparam int MEM_DW = 64;            // memory data width
    localparam int IF_DW  = 32;            // instruction word width
    localparam int MASK_W = MEM_DW / 8;    // byte-enable width

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_IF  = 3'd1,
        REQ_LS  = 3'd2,
        WAIT_IF = 3'd3,
        WAIT_LS = 3'd4
    } state_t;

    // Command captured at request acceptance and replayed on the memory port
    // for as long as the request phase lasts.
    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [MASK_W-1:0] wmask;
        logic              we;
    } mem_cmd_t;

    // Fetches always read the whole doubleword holding the instruction.
    function automatic logic [MEM_AW-1:0] dword_align(input logic [MEM_AW-1:0] a);
        return {a[MEM_AW-1:3], 3'b000};
    endfunction

    // Select the instruction word from a doubleword using address bit 2.
    function automatic logic [IF_DW-1:0] pick_word(input logic [MEM_DW-1:0] d,
                                                   input logic              hi);
        return hi ? d[MEM_DW-1:IF_DW] : d[IF_DW-1:0];
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch (IF) and load/store
// (LS) sides of a pipeline. Only one memory transaction is outstanding at a
// time; LS wins when both sides ask in the same idle cycle.
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   if_req/if_addr/if_flush fetch request, byte address, kill of current fetch
//   if_rdata/if_valid      fetched instruction word and its 1-cycle pulse
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wmask  load/store request
//   ls_rdata/ls_valid      load data (held) and completion pulse (also stores)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask  shared memory request
//   mem_gnt/mem_rvalid/mem_rdata  memory grant and response
//   if_stall/ls_stall      stall requests to the pipeline controller
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [MEM_AW-1:0] if_addr,
    input  logic              if_flush,
    output logic [IF_DW-1:0]  if_rdata,
    output logic              if_valid,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [MEM_AW-1:0] ls_addr,
    input  logic [MEM_DW-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic [MEM_DW-1:0] ls_rdata,
    output logic              ls_valid,

    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [MEM_DW-1:0] mem_rdata,

    output logic              if_stall,
    output logic              ls_stall
);

    state_t   state;
    mem_cmd_t cmd;
    logic     if_hi;   // captured if_addr[2]: which half of the dword to return
    logic     drop;    // fetch was flushed after grant; swallow its response

    // Byte-offset bits of the fetch address do not matter: whole dwords are read.
    logic unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmd      <= '0;
            if_hi    <= 1'b0;
            drop     <= 1'b0;
            if_rdata <= '0;
            if_valid <= 1'b0;
            ls_rdata <= '0;
            ls_valid <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            case (state)
                // A requester still holding req on its own valid cycle is the
                // tail of the finished transaction, not a new one.
                IDLE: begin
                    if (ls_req) begin
                        if (!ls_valid) begin
                            cmd   <= '{addr: ls_addr, wdata: ls_wdata,
                                       wmask: ls_wmask, we: ls_we};
                            state <= REQ_LS;
                        end
                    end else if (if_req && !if_flush && !if_valid) begin
                        cmd   <= '{addr: dword_align(if_addr), wdata: '0,
                                   wmask: '0, we: 1'b0};
                        if_hi <= if_addr[2];
                        state <= REQ_IF;
                    end
                end
                REQ_IF: begin
                    // A flush racing the grant cannot recall the request, so
                    // the transaction completes and its response is dropped.
                    if (mem_gnt) begin
                        state <= WAIT_IF;
                        drop  <= if_flush;
                    end else if (if_flush) begin
                        state <= IDLE;
                    end
                end
                REQ_LS: begin
                    if (mem_gnt) state <= WAIT_LS;
                end
                WAIT_IF: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!(drop || if_flush)) begin
                            if_valid <= 1'b1;
                            if_rdata <= pick_word(mem_rdata, if_hi);
                        end
                    end else if (if_flush) begin
                        drop <= 1'b1;
                    end
                end
                WAIT_LS: begin
                    if (mem_rvalid) begin
                        state    <= IDLE;
                        ls_valid <= 1'b1;
                        ls_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The memory command is a straight replay of the captured registers, so
    // it is stable for the whole request phase by construction.
    assign mem_req   = (state == REQ_IF) || (state == REQ_LS);
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_wmask = cmd.wmask;
    assign mem_we    = cmd.we;

    // Stalls are gated by reset so every output reads 0 while reset is held.
    assign ls_stall = rst && ls_req && !ls_valid;
    assign if_stall = rst && ((if_req && !if_valid) ||
                              (state == REQ_LS) || (state == WAIT_LS));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        if_req, if_flush, if_valid;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we, ls_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        if_stall, ls_stall;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .ls_stall(ls_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- transaction-level model ----
    // owner: 0 none, 1 fetch, 2 load/store; granted: request phase over
    int          m_owner;
    logic        m_granted, m_drop, m_hi, m_we;
    logic [63:0] m_addr, m_wdata, m_ls_rdata;
    logic [7:0]  m_wmask;
    logic [31:0] m_if_rdata;
    logic        m_if_valid, m_ls_valid;

    task automatic model_reset();
        m_owner = 0; m_granted = 1'b0; m_drop = 1'b0; m_hi = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_if_rdata = '0; m_ls_rdata = '0; m_if_valid = 1'b0; m_ls_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic ifv, lsv;
        ifv = 1'b0; lsv = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_owner == 0) begin
            if (ls_req) begin
                if (!m_ls_valid) begin
                    m_owner = 2; m_granted = 1'b0;
                    m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask; m_we = ls_we;
                end
            end else if (if_req && !if_flush && !m_if_valid) begin
                m_owner = 1; m_granted = 1'b0;
                m_addr = if_addr & ~64'h7; m_wdata = '0; m_wmask = '0; m_we = 1'b0;
                m_hi = if_addr[2];
            end
        end else if (!m_granted) begin
            if (mem_gnt) begin
                m_granted = 1'b1;
                m_drop = (m_owner == 1) && if_flush;
            end else if (m_owner == 1 && if_flush) begin
                m_owner = 0;
            end
        end else if (mem_rvalid) begin
            if (m_owner == 2) begin
                lsv = 1'b1; m_ls_rdata = mem_rdata;
            end else if (!(m_drop || if_flush)) begin
                ifv = 1'b1;
                m_if_rdata = m_hi ? mem_rdata[63:32] : mem_rdata[31:0];
            end
            m_owner = 0; m_drop = 1'b0;
        end else if (m_owner == 1 && if_flush) begin
            m_drop = 1'b1;
        end
        m_if_valid = ifv; m_ls_valid = lsv;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        logic exp_req;
        exp_req = rst && (m_owner != 0) && !m_granted;
        chk("mem_req", 64'(mem_req), 64'(exp_req));
        if (exp_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 64'(mem_we), 64'(m_we));
            chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
            if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_valid", 64'(if_valid), 64'(m_if_valid));
        chk("ls_valid", 64'(ls_valid), 64'(m_ls_valid));
        chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
        chk("ls_rdata", ls_rdata, m_ls_rdata);
        chk("if_stall", 64'(if_stall),
            64'(rst && ((if_req && !m_if_valid) || m_owner == 2)));
        chk("ls_stall", 64'(ls_stall), 64'(rst && ls_req && !m_ls_valid));
    endtask

    // Called at a negedge with inputs already set: compare, clock, return at
    // the next negedge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("rst mem_req", 64'(mem_req), 64'h0);
        chk("rst mem_addr", mem_addr, 64'h0);
        chk("rst mem_we", 64'(mem_we), 64'h0);
        chk("rst if_valid", 64'(if_valid), 64'h0);
        chk("rst ls_valid", 64'(ls_valid), 64'h0);
        chk("rst ls_rdata", ls_rdata, 64'h0);
        chk("rst if_stall", 64'(if_stall), 64'h0);
        chk("rst ls_stall", 64'(ls_stall), 64'h0);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_reset();
        #2;
        do_reset();
        rst = 1'b1;
        step();

        // single fetch, grant on the second request cycle
        if_req = 1'b1; if_addr = 64'h8000_0004;
        step();
        chk("s1 mem_addr", mem_addr, 64'h8000_0000);
        chk("s1 mem_wmask", 64'(mem_wmask), 64'h0);
        step();
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        step();
        chk("s1 if_valid", 64'(if_valid), 64'h1);
        chk("s1 if_rdata", 64'(if_rdata), 64'h1111_2222);
        if_req = 1'b0; mem_rvalid = 1'b0;
        step();
        chk("s1 single pulse", 64'(if_valid), 64'h0);

        // collision: load wins, fetch stalled until after ls_valid
        if_req = 1'b1; if_addr = 64'h8000_0020;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_1000;
        step();
        chk("s2 ls first", mem_addr, 64'h8000_1000);
        chk("s2 if_stall req", 64'(if_stall), 64'h1);
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0;
        chk("s2 if_stall wait", 64'(if_stall), 64'h1);
        mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        chk("s2 ls_valid", 64'(ls_valid), 64'h1);
        chk("s2 ls_rdata", ls_rdata, 64'h0123_4567_89AB_CDEF);
        chk("s2 if_stall", 64'(if_stall), 64'h1);
        ls_req = 1'b0; mem_rvalid = 1'b0;
        step();
        chk("s2 if issued", mem_addr, 64'h8000_0020);
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        chk("s2 if_rdata", 64'(if_rdata), 64'hCCCC_DDDD);
        if_req = 1'b0; mem_rvalid = 1'b0;
        step();

        // store held through a 3-cycle grant delay
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_2008;
        ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("s3 mem_we", 64'(mem_we), 64'h1);
            chk("s3 mem_wdata", mem_wdata, 64'hDEAD_BEEF);
            chk("s3 mem_wmask", 64'(mem_wmask), 64'h0F);
            step();
        end
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5;
        step();
        chk("s3 ls_valid", 64'(ls_valid), 64'h1);
        ls_req = 1'b0; ls_we = 1'b0; mem_rvalid = 1'b0;
        step();

        // flush while waiting, then a clean fetch
        if_req = 1'b1; if_addr = 64'h8000_0008;
        step();
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0; if_flush = 1'b1; step();
        if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        step();
        chk("s4 dropped", 64'(if_valid), 64'h0);
        if_addr = 64'h8000_0010; mem_rvalid = 1'b0;
        step();
        chk("s4 refetch addr", mem_addr, 64'h8000_0010);
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_5555_CCCC_7777;
        step();
        chk("s4 if_valid", 64'(if_valid), 64'h1);
        chk("s4 if_rdata", 64'(if_rdata), 64'hCCCC_7777);
        if_req = 1'b0; mem_rvalid = 1'b0;
        step();

        // reset while waiting on a load, stray rvalid afterwards
        ls_req = 1'b1; ls_addr = 64'h8000_3000;
        step();
        mem_gnt = 1'b1; step();
        mem_gnt = 1'b0;
        do_reset();
        rst = 1'b1; ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
        step();
        chk("s5 no ls_valid", 64'(ls_valid), 64'h0);
        chk("s5 no if_valid", 64'(if_valid), 64'h0);
        mem_rvalid = 1'b0;
        step();

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = 1'b1;
            if_flush = 1'b0;
            if (!if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1'b1; if_addr = rand_addr(); end
            end else if (m_if_valid) begin
                if ($urandom_range(1) == 0) if_req = 1'b0;
                else if_addr = rand_addr();
            end else if ($urandom_range(9) == 0) begin
                if_flush = 1'b1;
            end
            if (!ls_req || m_ls_valid) begin
                if (ls_req && $urandom_range(1) == 0) ls_req = 1'b0;
                else if (ls_req || $urandom_range(3) == 0) begin
                    ls_req = 1'b1; ls_we = 1'($urandom_range(1));
                    ls_addr = rand_addr(); ls_wdata = rand_addr();
                    ls_wmask = 8'($urandom_range(255));
                end
            end
            mem_gnt = ($urandom_range(2) != 0);
            if (m_owner != 0 && m_granted) mem_rvalid = 1'($urandom_range(1));
            else mem_rvalid = ($urandom_range(7) == 0);
            mem_rdata = rand_addr();
            if ($urandom_range(199) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
